// File: rtl/ez8_loader_pkg.sv
// Shared types and constants for the ez8 UART boot loader.
// Optional checksum stage is enabled by defining LOADER_CHECKSUM_EN.
package ez8_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    function automatic logic is_loading(input state_t s);
        return s inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
    endfunction

endpackage

// File: rtl/ez8_uart_rx.sv
// 8N1 UART receiver with input synchroniser and mid-bit sampling.
// Emits one-cycle valid or frame_err pulses at the stop-bit sample.
module ez8_uart_rx
    import ez8_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          sync1, sync2, prev;
    logic          valid_n, ferr_n;

    assign data = shift;

    // Two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            st        <= st_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
        end
    end

    // Bit timing: start re-checked at half bit, data/stop at full-bit steps
    always_comb begin
        st_n      = st;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        unique case (st)
            RX_IDLE: begin
                cnt_n = '0;
                if (prev && !sync2) st_n = RX_START;
            end
            RX_START: begin
                if (cnt == HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    st_n      = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL) begin
                    cnt_n     = '0;
                    shift_n   = {sync2, shift[7:1]};
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) st_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL) begin
                    cnt_n   = '0;
                    st_n    = RX_IDLE;
                    valid_n = sync2;
                    ferr_n  = !sync2;
                end
            end
            default: st_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/ez8_uart_loader.sv
// UART boot loader: writes a framed image into ez8 instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module ez8_uart_loader
    import ez8_loader_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 12,
    parameter int TIMEOUT    = 5000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  uart_rx,
    output logic [ADDR_WIDTH-1:0] instr_writeaddr,
    output logic [15:0]           instr_writedata,
    output logic                  instr_write_en,
    output logic                  cpu_reset,
    output logic                  load_busy,
    output logic                  load_error
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t FINAL = CHECK;
`else
    localparam state_t FINAL = DONE;
`endif

    state_t                state, next;
    logic [7:0]            rx_data;
    logic                  rx_valid, rx_ferr;
    logic [7:0]            len_hi, word_hi;
    logic [15:0]           len;
    logic [15:0]           new_len;
    logic [ADDR_WIDTH-1:0] idx;
    logic [TW-1:0]         timer;
    logic                  loading, hdr, last_word, timed_out;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            chk;
`endif

    ez8_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx       (uart_rx),
        .data     (rx_data),
        .valid    (rx_valid),
        .frame_err(rx_ferr)
    );

    assign loading    = is_loading(state);
    assign hdr        = rx_valid && !loading && rx_data == HEADER_BYTE;
    assign new_len    = {len_hi, rx_data};
    assign last_word  = (16'(idx) + 16'd1) == len;
    assign timed_out  = timer == TLAST;
    assign load_busy  = loading;
    assign load_error = state == ERROR;

    // Loader state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next;
    end

    // Frame parsing; framing errors and timeouts abort any load
    always_comb begin
        next = state;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (hdr) next = LEN_HI;
            end
            LEN_HI: begin
                if (rx_valid) next = LEN_LO;
            end
            LEN_LO: begin
                if (rx_valid) begin
                    if (new_len == 16'd0)                next = FINAL;
                    else if ({1'b0, new_len} > MAX_WORDS) next = ERROR;
                    else                                 next = DATA_HI;
                end
            end
            DATA_HI: begin
                if (rx_valid) next = DATA_LO;
            end
            DATA_LO: begin
                if (rx_valid) next = last_word ? FINAL : DATA_HI;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (rx_valid) next = (rx_data == chk) ? DONE : ERROR;
            end
`endif
            default: next = IDLE;
        endcase
        if (loading && (rx_ferr || (!rx_valid && timed_out))) next = ERROR;
    end

    // Length capture, word assembly, write port, timer and CPU reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_hi          <= '0;
            len             <= '0;
            word_hi         <= '0;
            idx             <= '0;
            timer           <= '0;
            instr_writeaddr <= '0;
            instr_writedata <= '0;
            instr_write_en  <= 1'b0;
            cpu_reset       <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            chk             <= '0;
`endif
        end else begin
            instr_write_en <= 1'b0;
            cpu_reset      <= state != DONE;
            if (!loading || rx_valid) timer <= '0;
            else                      timer <= timer + 1'b1;
            if (hdr) idx <= '0;
            if (rx_valid && state == LEN_HI)  len_hi  <= rx_data;
            if (rx_valid && state == LEN_LO)  len     <= new_len;
            if (rx_valid && state == DATA_HI) word_hi <= rx_data;
            if (rx_valid && state == DATA_LO) begin
                instr_write_en  <= 1'b1;
                instr_writeaddr <= idx;
                instr_writedata <= {word_hi, rx_data};
                idx             <= idx + 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            if (hdr) chk <= '0;
            if (rx_valid && (state == DATA_HI || state == DATA_LO))
                chk <= chk ^ rx_data;
`endif
        end
    end

endmodule
